array_mult_struct: RTL and testbench
====================================

# array_mult_struct

Unsigned 4x4 array multiplier built structurally from AND-gate partial products and a ripple array of full/half adders. It produces the 8-bit product combinationally. It also provides a registered copy of the product for synchronous consumers. It sits as a leaf arithmetic block, driven directly by input pins or upstream registers.

## Interface
Parameters:
- none. Widths are fixed at M_W=4, Q_W=4, P_W=8.

Ports:
- clk  input  1  system clock; rising edge active. One clock domain.
- rst_n  input  1  reset; asynchronous, active-low.
- m  input  4  multiplicand, unsigned.
- q  input  4  multiplier, unsigned.
- p  output  8  combinational product m*q, unsigned.
- p_q  output  8  registered product; holds the value of p sampled at the last rising edge of clk.

## Operation
- Partial products: pp[i][j] = m[j] & q[i], for i, j in 0..3.
- Row 0 passes straight through.
  - p[0] = pp[0][0].
- Each following row i (1..3) adds pp[i][*] to the shifted running sum of the previous row.
  - Use a 4-bit ripple of adders.
  - The carry-in of the LSB adder in each row is 0 (half adder allowed).
  - The carry-out of each row becomes the MSB of that row's sum.
- Output bit mapping:
  - p[i] is the LSB sum of row i, for i = 1..3.
  - p[7:4] come from the upper sum bits of row 3 plus that row's final carry-out.
- Result is the exact unsigned product with no truncation, since 15*15 = 225 fits in 8 bits.
- No signed mode, no saturation, no enable.
- p_q update:
  - On every rising clk edge, p_q <= p.
  - While rst_n = 0, p_q = 8'h00.
- Combinational path p is independent of clk and rst_n. p stays valid during reset.

## Timing
- p: zero-cycle latency; purely combinational.
  - Must settle within the clock period.
  - Critical path is about 3 rows plus the final carry ripple.
- p_q: one-cycle latency; value is m*q sampled at the capturing edge.
- Reset:
  - Asserting rst_n = 0 clears p_q to 0 immediately, with no clock required.
  - Release is synchronized to clk by the integrator.
  - The first capture happens at the first rising edge after rst_n goes high.
- Inputs changing between edges affect p immediately. They affect p_q only at the next edge.
- Reset asserted mid-operation: p_q clears, and p keeps tracking m and q.

## Structure
- Sub-module full_adder (a, b, cin -> s, cout), instantiated 12 times.
  - An optional half_adder may replace the row-LSB cells.
- Partial-product AND array and adder rows are generated in the top module.
- Shared package (array_mult_pkg): localparams M_W=4, Q_W=4, P_W=M_W+Q_W.
  - No typedefs needed.
- Output register is a single always block with async active-low clear.

## Test plan
- Directed vectors (m, q -> p):
  - 0, 0 -> 0x00.
  - 1, 1 -> 0x01.
  - 2, 2 -> 0x04.
  - 6, 2 -> 0x0C.
  - 6, 15 -> 0x5A.
  - 7, 15 -> 0x69.
  - 6, 0 -> 0x00.
  - 5, 10 -> 0x32.
  - 8, 8 -> 0x40.
  - 7, 8 -> 0x38.
  - 15, 15 -> 0xE1.
  - Check p after settling and before the next input change.
- Exhaustive sweep of all 256 (m, q) pairs: p == m*q for every pair. Report a failure count and pass only if it is zero.
- Registered path: apply m=7, q=15 before a rising edge -> p_q = 0x69 after that edge. Change inputs mid-cycle -> p_q unchanged until the next edge.
- Reset behaviour:
  - Hold rst_n = 0 with m=15, q=15 -> p_q = 0x00 and p = 0xE1.
  - Deassert -> p_q = 0xE1 after the first edge.
- Async clear: with p_q = 0x5A, drop rst_n between clock edges -> p_q = 0x00 without a clock edge.

Source files
------------

// File: rtl/array_mult_pkg.sv
// Width constants shared by the 4x4 structural array multiplier.
package array_mult_pkg;
  localparam int M_W = 4;
  localparam int Q_W = 4;
  localparam int P_W = M_W + Q_W;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used throughout the multiplier adder array.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/array_mult_struct.sv
// Unsigned 4x4 array multiplier: AND partial products, three 4-bit ripple rows,
// combinational product plus a registered copy with async active-low clear.
module array_mult_struct
  import array_mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M_W-1:0] m,
  input  logic [Q_W-1:0] q,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] p_q
);

  // Row i adds pp[i][*] to the previous row's sum shifted down one bit, with that
  // row's carry-out entering as the new MSB. Row 0 is the raw pp[0][*] vector.
  for (genvar gi = 1; gi < Q_W; gi++) begin : g_row
    for (genvar gj = 0; gj < M_W; gj++) begin : g_col
      logic a_bit;
      logic b_bit;
      logic ci;
      logic s;
      logic co;

      assign a_bit = m[gj] & q[gi];

      if (gj == 0) begin : g_lsb
        assign ci = 1'b0;
      end else begin : g_mid
        assign ci = g_row[gi].g_col[gj-1].co;
      end

      if (gi == 1) begin : g_first
        if (gj == M_W - 1) begin : g_top
          assign b_bit = 1'b0;
        end else begin : g_pp
          assign b_bit = m[gj+1] & q[0];
        end
      end else begin : g_next
        if (gj == M_W - 1) begin : g_top
          assign b_bit = g_row[gi-1].g_col[M_W-1].co;
        end else begin : g_sum
          assign b_bit = g_row[gi-1].g_col[gj+1].s;
        end
      end

      full_adder u_fa (
        .a    (a_bit),
        .b    (b_bit),
        .cin  (ci),
        .s    (s),
        .cout (co)
      );
    end
  end

  assign p[0] = m[0] & q[0];
  assign p[1] = g_row[1].g_col[0].s;
  assign p[2] = g_row[2].g_col[0].s;
  assign p[3] = g_row[3].g_col[0].s;
  assign p[4] = g_row[3].g_col[1].s;
  assign p[5] = g_row[3].g_col[2].s;
  assign p[6] = g_row[3].g_col[3].s;
  assign p[7] = g_row[3].g_col[3].co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p;
  end

endmodule

// File: tb/tb_array_mult_struct.sv
// Directed and exhaustive checks of array_mult_struct, combinational and registered paths.
module tb_array_mult_struct;
  logic       clk;
  logic       rst_n;
  logic [3:0] m;
  logic [3:0] q;
  logic [7:0] p;
  logic [7:0] p_q;

  int n_checks = 0;
  int n_fails  = 0;
  int sweep_fails = 0;

  array_mult_struct dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (m),
    .q     (q),
    .p     (p),
    .p_q   (p_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp_val);
    end
  endtask

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] p;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{4'd0,  4'd0,  8'h00};
    vecs[1]  = '{4'd1,  4'd1,  8'h01};
    vecs[2]  = '{4'd2,  4'd2,  8'h04};
    vecs[3]  = '{4'd6,  4'd2,  8'h0C};
    vecs[4]  = '{4'd6,  4'd15, 8'h5A};
    vecs[5]  = '{4'd7,  4'd15, 8'h69};
    vecs[6]  = '{4'd6,  4'd0,  8'h00};
    vecs[7]  = '{4'd5,  4'd10, 8'h32};
    vecs[8]  = '{4'd8,  4'd8,  8'h40};
    vecs[9]  = '{4'd7,  4'd8,  8'h38};
    vecs[10] = '{4'd15, 4'd15, 8'hE1};

    // Reset held with full-scale inputs
    rst_n = 1'b0;
    m = 4'd15;
    q = 4'd15;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_p_q", p_q, 8'h00);
    chk("reset_p", p, 8'hE1);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_p_q", p_q, 8'hE1);

    // Directed combinational vectors
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      m = vecs[i].m;
      q = vecs[i].q;
      #1;
      chk($sformatf("dir_p_%0d", i), p, vecs[i].p);
    end

    // Registered path: capture, then mid-cycle input change must not reach p_q
    @(negedge clk);
    m = 4'd7;
    q = 4'd15;
    @(posedge clk);
    #1;
    chk("reg_capture", p_q, 8'h69);
    #2;
    m = 4'd1;
    q = 4'd1;
    #1;
    chk("reg_hold", p_q, 8'h69);
    chk("reg_hold_p", p, 8'h01);
    @(posedge clk);
    #1;
    chk("reg_next", p_q, 8'h01);

    // Asynchronous clear between edges
    @(negedge clk);
    m = 4'd6;
    q = 4'd15;
    @(posedge clk);
    #1;
    chk("async_pre", p_q, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", p_q, 8'h00);
    chk("async_p", p, 8'h5A);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("async_recover", p_q, 8'h5A);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int f0;
        logic [7:0] want;
        want = 8'(a * b);
        m = 4'(a);
        q = 4'(b);
        #1;
        f0 = n_fails;
        chk($sformatf("sweep_%0d_%0d", a, b), p, want);
        if (n_fails != f0) sweep_fails++;
      end
    end
    chk("sweep_fail_count", 8'(sweep_fails), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
